// File: rtl/bullet_controller_if.sv
// bullet_controller_if: fire/kill requests into the bullet pool and its status back out.
//   fire      shot request (level, auto-repeat while held)
//   ship_x    spawn column, sampled when a shot is accepted
//   hit       per-slot kill request from collision logic
//   active    registered slot-valid vector
//   fire_ack  one-cycle pulse after the edge that accepted a shot
//   cooling   high while the cooldown counter is non-zero
//   shots     count of accepted shots, wraps 255 -> 0
interface bullet_controller_if #(
    parameter int NUM_SLOTS = 4
);
    logic                 fire;
    logic [9:0]           ship_x;
    logic [NUM_SLOTS-1:0] hit;
    logic [NUM_SLOTS-1:0] active;
    logic                 fire_ack;
    logic                 cooling;
    logic [7:0]           shots;

    modport master (
        output fire, ship_x, hit,
        input  active, fire_ack, cooling, shots
    );

    modport slave (
        input  fire, ship_x, hit,
        output active, fire_ack, cooling, shots
    );
endinterface

// File: rtl/bullet_controller.sv
// bullet_controller: pool of player bullets with fire cooldown, upward motion and pixel output.
//   clk_60hz  game tick clock, all state updates on its rising edge
//   resetn    asynchronous active-low reset
//   bus       slave side of bullet_controller_if (fire/ship_x/hit in, status out)
//   px, py    current VGA pixel coordinate
//   pixel     combinational: current pixel lies on a live bullet (2x6 sprite)
module bullet_controller #(
    parameter int NUM_SLOTS = 4,
    parameter int SPEED     = 4,
    parameter int COOLDOWN  = 15,
    parameter int SPAWN_Y   = 232
) (
    input  logic                clk_60hz,
    input  logic                resetn,
    bullet_controller_if.slave  bus,
    input  logic [9:0]          px,
    input  logic [9:0]          py,
    output logic                pixel
);
    localparam int CW = COOLDOWN > 0 ? $clog2(COOLDOWN + 1) : 1;
    localparam int SW = NUM_SLOTS > 1 ? $clog2(NUM_SLOTS) : 1;

    logic [NUM_SLOTS-1:0] valid;
    logic [9:0]           xs [NUM_SLOTS];
    logic [9:0]           ys [NUM_SLOTS];
    logic [CW-1:0]        cd;
    logic                 fire_ack_q;
    logic                 cooling_q;
    logic [7:0]           shots_q;
    logic [SW-1:0]        sel;
    logic                 accept;

    // Lowest-index free slot; scanning downward lets the lowest index win.
    always_comb begin
        sel = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--)
            if (!valid[i]) sel = SW'(i);
    end

    assign accept = bus.fire && cd == '0 && !(&valid);

    always_ff @(posedge clk_60hz or negedge resetn) begin
        if (!resetn) begin
            valid      <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                xs[i] <= '0;
                ys[i] <= '0;
            end
            cd         <= '0;
            fire_ack_q <= 1'b0;
            cooling_q  <= 1'b0;
            shots_q    <= '0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                // Retire before y would underflow past the top of the screen.
                if (valid[i] && (bus.hit[i] || ys[i] < 10'(SPEED)))
                    valid[i] <= 1'b0;
                else if (valid[i])
                    ys[i] <= ys[i] - 10'(SPEED);
            end
            // The chosen slot was free before the edge, so the motion/kill
            // loop never touched it and a same-edge hit on it is moot.
            if (accept) begin
                valid[sel] <= 1'b1;
                xs[sel]    <= bus.ship_x;
                ys[sel]    <= 10'(SPAWN_Y);
                cd         <= CW'(COOLDOWN);
                cooling_q  <= COOLDOWN != 0;
                shots_q    <= shots_q + 8'd1;
            end else begin
                cd         <= cd - CW'(cd != '0);
                cooling_q  <= cd > CW'(1);
            end
            fire_ack_q <= accept;
        end
    end

    // 11-bit compares keep x+1 and y+5 from wrapping at the screen edge.
    always_comb begin
        pixel = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++)
            if (valid[i]
                && {1'b0, px} >= {1'b0, xs[i]} && {1'b0, px} <= {1'b0, xs[i]} + 11'd1
                && {1'b0, py} >= {1'b0, ys[i]} && {1'b0, py} <= {1'b0, ys[i]} + 11'd5)
                pixel = 1'b1;
    end

    assign bus.active   = valid;
    assign bus.fire_ack = fire_ack_q;
    assign bus.cooling  = cooling_q;
    assign bus.shots    = shots_q;
endmodule

// File: tb/tb_bullet_controller.sv
// tb_bullet_controller: scoreboard bench for bullet_controller (default and short-cooldown instances).
module tb_bullet_controller;
    logic       clk_60hz = 1'b0;
    logic       resetn   = 1'b0;
    logic [9:0] px       = '0;
    logic [9:0] py       = '0;
    logic       pixel1;
    logic       pixel2;
    int         checks   = 0;
    int         failures = 0;

    typedef struct packed {
        logic [7:0] shots;
        logic [3:0] act;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    exp_t e1;
    exp_t e2;

    bullet_controller_if #(.NUM_SLOTS(4)) bus1 ();
    bullet_controller_if #(.NUM_SLOTS(4)) bus2 ();

    bullet_controller dut1 (
        .clk_60hz (clk_60hz),
        .resetn   (resetn),
        .bus      (bus1.slave),
        .px       (px),
        .py       (py),
        .pixel    (pixel1)
    );

    // Short cooldown so the pool can fill while cooldown is already zero.
    bullet_controller #(.COOLDOWN(1)) dut2 (
        .clk_60hz (clk_60hz),
        .resetn   (resetn),
        .bus      (bus2.slave),
        .px       (px),
        .py       (py),
        .pixel    (pixel2)
    );

    always #5 clk_60hz = ~clk_60hz;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_60hz);
        #2;
    endtask

    task automatic pix1(input string name, input int x, input int y, input logic exp);
        px = 10'(x);
        py = 10'(y);
        #1;
        chk(name, 32'(pixel1), 32'(exp));
    endtask

    // Monitor: every ack pops the next expected shot and checks the status it reports.
    always @(posedge clk_60hz) begin
        #1;
        if (bus1.fire_ack) begin
            if (q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dut1_spurious_ack actual=ack required=no_ack");
            end else begin
                e1 = q1.pop_front();
                chk("dut1_ack_shots", 32'(bus1.shots), 32'(e1.shots));
                chk("dut1_ack_active", 32'(bus1.active), 32'(e1.act));
            end
        end
        if (bus2.fire_ack) begin
            if (q2.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dut2_spurious_ack actual=ack required=no_ack");
            end else begin
                e2 = q2.pop_front();
                chk("dut2_ack_shots", 32'(bus2.shots), 32'(e2.shots));
                chk("dut2_ack_active", 32'(bus2.active), 32'(e2.act));
            end
        end
    end

    initial begin
        bus1.fire = 1'b0; bus1.ship_x = '0; bus1.hit = '0;
        bus2.fire = 1'b0; bus2.ship_x = '0; bus2.hit = '0;
        #12;
        chk("rst_active", 32'(bus1.active), 0);
        chk("rst_shots", 32'(bus1.shots), 0);
        chk("rst_cooling", 32'(bus1.cooling), 0);
        chk("rst_ack", 32'(bus1.fire_ack), 0);
        chk("rst_pixel", 32'(pixel1), 0);
        resetn = 1'b1;

        // Idle: no fire, nothing happens.
        for (int i = 0; i < 10; i++) tick();
        chk("idle_active", 32'(bus1.active), 0);
        chk("idle_shots", 32'(bus1.shots), 0);

        // Single shot at x=100 and its full lifetime.
        bus1.ship_x = 10'd100;
        bus1.fire   = 1'b1;
        q1.push_back(exp_t'{8'd1, 4'b0001});
        tick();
        bus1.fire = 1'b0;
        chk("shot_cooling", 32'(bus1.cooling), 1);
        pix1("spawn_y232", 100, 232, 1'b1);
        tick();
        chk("ack_one_cycle", 32'(bus1.fire_ack), 0);
        pix1("pix_100_228", 100, 228, 1'b1);
        pix1("pix_101_233", 101, 233, 1'b1);
        pix1("pix_102_228", 102, 228, 1'b0);
        pix1("pix_100_227", 100, 227, 1'b0);
        pix1("pix_101_234", 101, 234, 1'b0);
        for (int n = 2; n <= 59; n++) begin
            tick();
            if (n == 14) chk("cooling_edge14", 32'(bus1.cooling), 1);
            if (n == 15) chk("cooling_edge15", 32'(bus1.cooling), 0);
            if (n == 58) begin
                chk("alive_edge58", 32'(bus1.active), 32'h1);
                pix1("pix_y0_edge58", 100, 0, 1'b1);
            end
            if (n == 59) chk("retired_edge59", 32'(bus1.active), 0);
        end

        // Fire held for 70 edges: accepts every 16 edges, slot 0 reused at 64.
        resetn = 1'b0;
        #3;
        resetn = 1'b1;
        bus1.ship_x = 10'd200;
        bus1.fire   = 1'b1;
        for (int e = 0; e < 70; e++) begin
            if (e % 16 == 0)
                q1.push_back(exp_t'{8'(e / 16 + 1),
                    e == 0 ? 4'h1 : e == 16 ? 4'h3 : e == 32 ? 4'h7 : 4'hF});
            tick();
            if (e == 58) chk("hold_active58", 32'(bus1.active), 32'hF);
            if (e == 59) chk("hold_active59", 32'(bus1.active), 32'hE);
            if (e == 62) chk("hold_cooling62", 32'(bus1.cooling), 1);
            if (e == 63) chk("hold_cooling63", 32'(bus1.cooling), 0);
        end
        bus1.fire = 1'b0;
        chk("hold_shots", 32'(bus1.shots), 5);
        chk("hold_queue_empty", 32'(q1.size()), 0);

        // Short-cooldown instance: full pool drop, hit while full, hit on allocated slot.
        resetn = 1'b0;
        #3;
        resetn = 1'b1;
        bus2.ship_x = 10'd50;
        bus2.fire   = 1'b1;
        for (int e = 0; e < 8; e++) begin
            if (e % 2 == 0)
                q2.push_back(exp_t'{8'(e / 2 + 1),
                    e == 0 ? 4'h1 : e == 2 ? 4'h3 : e == 4 ? 4'h7 : 4'hF});
            tick();
        end
        chk("full_cooling", 32'(bus2.cooling), 0);
        tick();
        chk("full_drop_ack", 32'(bus2.fire_ack), 0);
        chk("full_drop_shots", 32'(bus2.shots), 4);
        chk("full_drop_active", 32'(bus2.active), 32'hF);
        chk("full_drop_cooling", 32'(bus2.cooling), 0);
        bus2.hit = 4'b0100;
        tick();
        chk("hit_full_active", 32'(bus2.active), 32'hB);
        chk("hit_full_ack", 32'(bus2.fire_ack), 0);
        chk("hit_full_shots", 32'(bus2.shots), 4);
        bus2.hit = 4'b0000;
        q2.push_back(exp_t'{8'd5, 4'hF});
        tick();
        bus2.fire = 1'b0;
        bus2.hit  = 4'b0010;
        tick();
        chk("kill_slot1", 32'(bus2.active), 32'hD);
        bus2.fire   = 1'b1;
        bus2.ship_x = 10'd300;
        bus2.hit    = 4'b0010;
        q2.push_back(exp_t'{8'd6, 4'hF});
        tick();
        bus2.fire = 1'b0;
        bus2.hit  = 4'b0000;
        px = 10'd300; py = 10'd232; #1;
        chk("alloc_hit_pix232", 32'(pixel2), 1);
        py = 10'd231; #1;
        chk("alloc_hit_pix231", 32'(pixel2), 0);
        chk("dut2_queue_empty", 32'(q2.size()), 0);

        // Asynchronous reset mid-flight, then fire accepted on the first edge.
        bus1.ship_x = 10'd10;
        bus1.fire   = 1'b1;
        q1.push_back(exp_t'{8'd1, 4'b0001});
        tick();
        bus1.fire = 1'b0;
        tick();
        tick();
        chk("pre_rst_cooling", 32'(bus1.cooling), 1);
        pix1("pre_rst_pixel", 10, 226, 1'b1);
        #1;
        resetn = 1'b0;
        #1;
        chk("async_active", 32'(bus1.active), 0);
        chk("async_cooling", 32'(bus1.cooling), 0);
        chk("async_shots", 32'(bus1.shots), 0);
        chk("async_pixel", 32'(pixel1), 0);
        bus1.fire = 1'b1;
        q1.push_back(exp_t'{8'd1, 4'b0001});
        #2;
        resetn = 1'b1;
        tick();
        bus1.fire = 1'b0;
        chk("post_rst_ack", 32'(bus1.fire_ack), 1);
        tick();
        chk("final_queue_empty", 32'(q1.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
